// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, schedule length, RCON
// bytes, word type and key-FSM state encoding.
package aes_pkg;

  localparam int NR     = 10;
  localparam int NWORDS = 4 * (NR + 1);

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } key_state_t;

endpackage

// File: rtl/key_word_gen.sv
// Combinational next-word logic for AES-128 key expansion: RotWord for the
// S-box request and the w[i-4] XOR (with SubWord/RCON on every fourth word).
module key_word_gen
  import aes_pkg::*;
(
  input  logic [5:0] idx,
  input  word_t      w_back4,
  input  word_t      w_back1,
  input  word_t      sub_result,
  output word_t      rot_word,
  output word_t      next_word
);

  logic [3:0] rcon_sel;
  logic [7:0] rcon_byte;

  always_comb begin
    rot_word  = {w_back1[23:0], w_back1[31:24]};
    rcon_sel  = idx[5:2] - 4'd1;
    rcon_byte = (rcon_sel < 4'(NR)) ? RCON[rcon_sel] : 8'h00;
    if (idx[1:0] == 2'b00)
      next_word = w_back4 ^ sub_result ^ {rcon_byte, 24'h0};
    else
      next_word = w_back4 ^ w_back1;
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer: one schedule word per cycle, shared S-box
// borrowed via req/gnt, round-key store with a one-cycle-latency read port.
//
// state | meaning
// IDLE  | no key loaded since reset
// GEN   | generating w[idx]; stalls while an S-box request is not granted
// DONE  | all 44 words valid, round-key reads served
module key_expand_ctrl
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_expand_done,
  output logic         sbox_req,
  output logic [31:0]  sbox_word,
  input  logic         sbox_gnt,
  input  logic [31:0]  sbox_result,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_round,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [5:0]   dbg_word_idx
);

  key_state_t state, state_nxt;
  word_t      w [NWORDS];
  logic [5:0] idx;
  logic [5:0] rk_base;
  word_t      rot_word, next_word;
  logic       word_we;

  key_word_gen u_word_gen (
    .idx        (idx),
    .w_back4    (w[idx - 6'd4]),
    .w_back1    (w[idx - 6'd1]),
    .sub_result (sbox_result),
    .rot_word   (rot_word),
    .next_word  (next_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    key_expand_done = 1'b0;
    sbox_req        = 1'b0;
    word_we         = 1'b0;
    case (state)
      IDLE: ;
      GEN: begin
        busy     = 1'b1;
        sbox_req = (idx[1:0] == 2'b00);
        word_we  = !sbox_req || sbox_gnt;
        if (word_we && idx == 6'(NWORDS - 1))
          state_nxt = DONE;
      end
      DONE: key_expand_done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // A new key always restarts, whatever the current state.
    if (key_load)
      state_nxt = GEN;
  end

  assign sbox_word    = sbox_req ? rot_word : 32'h0;
  assign dbg_word_idx = idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= 6'd0;
      for (int i = 0; i < NWORDS; i++)
        w[i] <= '0;
    end else if (key_load) begin
      w[0] <= key_in[127:96];
      w[1] <= key_in[95:64];
      w[2] <= key_in[63:32];
      w[3] <= key_in[31:0];
      idx  <= 6'd4;
    end else if (word_we) begin
      w[idx] <= next_word;
      idx    <= idx + 6'd1;
    end
  end

  assign rk_base = {rk_round, 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rk_valid <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= 1'b0;
      if (rk_rd_en) begin
        if (state == DONE && rk_round <= 4'(NR)) begin
          rk_valid <= 1'b1;
          rk_data  <= {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
        end else begin
          rk_data  <= '0;
        end
      end
    end
  end

endmodule

// File: doc/key_expand_ctrl.md
Name: key_expand_ctrl

Overview:
Sequences AES-128 key expansion one 32-bit word per cycle, from the 128-bit cipher key to all 44 schedule words (round keys 0..10). Borrows the shared 4-byte S-box through a request/grant handshake, because the round datapath also uses that S-box.
Stores the schedule and serves round-key reads to state_manager. Drives key_expand_done, which state_manager waits on before starting rounds.

Parameters:
NR, 10, number of AES rounds; round keys 0..NR are stored.
NWORDS, 44, schedule length in words, 4*(NR+1).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-high
key_load  in  1  one-cycle pulse; latch key_in and (re)start expansion
key_in  in  128  cipher key; key_in[127:96]=w0 ... key_in[31:0]=w3
busy  out  1  expansion in progress
key_expand_done  out  1  level; all 44 words valid
sbox_req  out  1  request for the shared S-box
sbox_word  out  32  RotWord(w[i-1]) presented to the S-box
sbox_gnt  in  1  grant; sbox_result is valid in the same cycle as the grant (combinational S-box)
sbox_result  in  32  SubWord(sbox_word)
rk_rd_en  in  1  round-key read strobe
rk_round  in  4  round index 0..10
rk_valid  out  1  rk_data valid
rk_data  out  128  round key; [127:96]=w[4r] ... [31:0]=w[4r+3]
dbg_word_idx  out  6  index of the next word to generate (4..44)

Behaviour:
- Reset value of every output and register is 0: busy, key_expand_done, sbox_req, sbox_word, rk_valid, rk_data, dbg_word_idx, and the word store.
- FSM states: IDLE, GEN, DONE.
  - IDLE: key_load writes w0..w3 from key_in, sets idx=4, goes to GEN with busy=1.
  - GEN, idx%4!=0: w[idx] = w[idx-4] ^ w[idx-1]; one word per cycle; idx increments.
  - GEN, idx%4==0: sbox_req=1 and sbox_word={w[idx-1][23:0], w[idx-1][31:24]}.
    - In a cycle with sbox_gnt=1: w[idx] = w[idx-4] ^ sbox_result ^ {RCON[idx/4-1], 24'h0}; idx increments.
    - sbox_gnt=0: stall and hold all state; sbox_req stays high.
  - GEN -> DONE on the edge that writes w43: busy=0, key_expand_done=1, sbox_req=0.
  - DONE: key_expand_done holds until the next key_load or reset.
- Latency with sbox_gnt held at 1: key_load sampled at edge E0 writes w0..w3. Words w4..w43 are written at E1..E40. key_expand_done is high after E40. Each cycle with a denied request adds exactly one cycle.
- key_load in GEN aborts the current run and restarts with the new key, exactly as from IDLE.
- key_load in DONE clears key_expand_done at that same edge and restarts.
- Read port, one-cycle latency: rk_rd_en sampled at edge E gives rk_valid=1 and rk_data after E.
  - rk_valid=0 and rk_data=0 if key_expand_done=0 at E, or if rk_round>10.
  - Reads do not disturb expansion.
- Simultaneous key_load and rk_rd_en: the read sees pre-edge key_expand_done; the restart wins.
- Asynchronous reset mid-expansion returns to IDLE immediately and clears the store.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.

Decomposition:
- aes_pkg holds the shared definitions:
  - NR and NWORDS;
  - the RCON[0:9] byte array;
  - typedef word_t = logic[31:0];
  - the key-FSM state enum (IDLE/GEN/DONE).
- One sub-module, key_word_gen: combinational next-word logic (RotWord, RCON XOR, w[i-4] XOR).
- The store and the FSM stay in key_expand_ctrl.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, gnt tied 1, model S-box in bench.
   - w4 = a0fafe17.
   - Round 1 = a0fafe1788542cb123a339392a6c7605.
   - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - key_expand_done rises exactly 40 cycles after key_load.
2. Same key, sbox_gnt low for 3 cycles on each request. Done arrives at 40+30=70 cycles; round keys are identical to scenario 1.
3. Read round 0 in DONE: rk_data=2b7e151628aed2a6abf7158809cf4f3c one cycle later.
   - Read rk_round=11: rk_valid=0.
   - Read during GEN: rk_valid=0.
4. key_load with key 000...0 at idx=20 of a run. Restart: busy stays 1, dbg_word_idx=4.
   - Final round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
5. Assert reset at idx=30: all outputs 0 immediately (asynchronous).
   - Then key_load with the A.1 key gives the scenario-1 results.
6. key_load in DONE: key_expand_done=0 at the next edge, and rises again 40 cycles later.
